// File: rtl/base_hps_clken_pkg.sv
// Shared types and helpers for the HPS clock-enable generator.
package base_hps_clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int CHAN_IDX_W = 3;

    // Pulse position clamped into the period; callers zero-extend to 32 bits.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] div);
        logic [31:0] res;
        res = phase;
        if (div == 32'd0) begin
            res = 32'd0;
        end else if (phase > div - 32'd1) begin
            res = div - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/base_hps_clken_chan.sv
// One divided clock-enable channel: div/phase/cnt registers, update-on-wrap and pulse decode.
module base_hps_clken_chan
    import base_hps_clken_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             leave_run_i,
    input  logic             upd_i,
    input  logic [DIV_W-1:0] upd_div_i,
    input  logic [DIV_W-1:0] upd_phase_i,
    output logic             taken_o,
    output logic             clken_o
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] phase_eff;
    logic             div_nz;
    logic             wrap;

    assign div_nz    = (div_q != '0);
    assign wrap      = div_nz && (cnt_q == div_q - ONE);
    assign phase_eff = DIV_W'(clamp_phase(32'(phase_q), 32'(div_q)));

    // A pending update lands only where it cannot truncate a running period.
    assign taken_o = upd_i && (!run_i || !div_nz || wrap || leave_run_i);
    assign clken_o = run_i && div_nz && (cnt_q == phase_eff);

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (taken_o) begin
            div_d   = upd_div_i;
            phase_d = upd_phase_i;
            cnt_d   = '0;
        end else if (!run_i || leave_run_i) begin
            cnt_d = '0;
        end else if (div_nz) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= DIV_RST;
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/base_hps_clken_gen.sv
// Lock-qualified multi-channel clock-enable generator behind the HPS fabric PLL.
// Define CLKEN_GEN_STATUS_EN to build the saturating lock-loss counter.
module base_hps_clken_gen
    import base_hps_clken_pkg::*;
#(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 256,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked_in,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_IDX_W-1:0] cfg_chan,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    output logic [NUM_CLOCKS-1:0] clken,
    output logic                  locked,
    output logic [7:0]            lock_loss_cnt
);

    localparam int                    SETTLE_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [CHAN_IDX_W:0]   NUM_CHAN    = (CHAN_IDX_W + 1)'(NUM_CLOCKS);

    logic                  sync1_q;
    logic                  lk_q;
    state_e                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [CHAN_IDX_W-1:0] pend_chan_q;
    logic [DIV_W-1:0]      pend_div_q;
    logic [DIV_W-1:0]      pend_phase_q;
    logic [NUM_CLOCKS-1:0] taken;
    logic                  run;
    logic                  leave_run;
    logic                  accept;
    logic                  chan_ok;

    assign run       = (state_q == RUN);
    assign leave_run = run && !lk_q;
    assign locked    = run;
    assign cfg_ready = !pend_vld_q;
    assign accept    = cfg_valid && !pend_vld_q;
    assign chan_ok   = ({1'b0, cfg_chan} < NUM_CHAN);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lk_q) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!lk_q) begin
                    state_d = WAIT_LOCK;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + SETTLE_ONE;
                end
            end
            RUN: begin
                if (!lk_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Out-of-range channel requests are accepted but never occupy the slot.
    always_comb begin
        pend_vld_d = pend_vld_q;
        if (|taken) begin
            pend_vld_d = 1'b0;
        end else if (accept && chan_ok) begin
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            lk_q         <= 1'b0;
            state_q      <= WAIT_LOCK;
            settle_q     <= '0;
            pend_vld_q   <= 1'b0;
            pend_chan_q  <= '0;
            pend_div_q   <= '0;
            pend_phase_q <= '0;
        end else begin
            sync1_q    <= pll_locked_in;
            lk_q       <= sync1_q;
            state_q    <= state_d;
            settle_q   <= settle_d;
            pend_vld_q <= pend_vld_d;
            if (accept && chan_ok) begin
                pend_chan_q  <= cfg_chan;
                pend_div_q   <= cfg_div;
                pend_phase_q <= cfg_phase;
            end
        end
    end

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        base_hps_clken_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i       (refclk),
            .rst_ni      (rst_n),
            .run_i       (run),
            .leave_run_i (leave_run),
            .upd_i       (pend_vld_q && (pend_chan_q == CHAN_IDX_W'(g))),
            .upd_div_i   (pend_div_q),
            .upd_phase_i (pend_phase_q),
            .taken_o     (taken[g]),
            .clken_o     (clken[g])
        );
    end

`ifdef CLKEN_GEN_STATUS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] loss_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (leave_run) begin
            loss_q <= sat_inc8(loss_q);
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_base_hps_clken_gen.sv
// Self-checking bench for base_hps_clken_gen: vector table per configuration plus lock/update/reset sequences.
module tb_base_hps_clken_gen;

    localparam int NCH = 4;

    logic           refclk;
    logic           rst_n;
    logic           pll_locked_in;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_chan;
    logic [15:0]    cfg_div;
    logic [15:0]    cfg_phase;
    logic [NCH-1:0] clken;
    logic           locked;
    logic [7:0]     lock_loss_cnt;

    // One channel of a vector row: divider, phase, and pulse mask for RUN cycles 0..11.
    typedef struct packed {
        logic [15:0] div;
        logic [15:0] ph;
        logic [11:0] mask;
    } vec_t;

    vec_t           rows [3][NCH];
    logic [3:0]     sb_q [$];
    int             n_vec  = 0;
    int             n_miss = 0;
    int             drops  = 0;

    base_hps_clken_gen #(
        .NUM_CLOCKS  (NCH),
        .DIV_W       (16),
        .LOCK_CYCLES (8),
        .DEFAULT_DIV (1)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked_in (pll_locked_in),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_chan      (cfg_chan),
        .cfg_div       (cfg_div),
        .cfg_phase     (cfg_phase),
        .clken         (clken),
        .locked        (locked),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_loss(input int n);
`ifdef CLKEN_GEN_STATUS_EN
        return (n > 255) ? 32'd255 : 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic sb_check(input string name);
        logic [3:0] e;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
        chk(name, 32'(clken), 32'(e));
    endtask

    task automatic drive(input logic [2:0] ch, input logic [15:0] dv, input logic [15:0] ph);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_div   = dv;
        cfg_phase = ph;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [15:0] dv, input logic [15:0] ph);
        int guard;
        guard = 0;
        while (!cfg_ready && guard < 64) begin
            @(negedge refclk);
            guard++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        drive(ch, dv, ph);
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    task automatic unlock();
        int guard;
        pll_locked_in = 1'b0;
        guard = 0;
        while (locked && guard < 16) begin
            @(negedge refclk);
            guard++;
        end
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_clken", 32'(clken), 32'd0);
    endtask

    task automatic relock(output int cyc);
        pll_locked_in = 1'b1;
        cyc = 0;
        do begin
            @(negedge refclk);
            cyc++;
        end while (!locked && cyc < 100);
    endtask

    initial begin
        int         n;
        logic [3:0] e;

        rst_n         = 1'b0;
        pll_locked_in = 1'b0;
        cfg_valid     = 1'b0;
        cfg_chan      = '0;
        cfg_div       = '0;
        cfg_phase     = '0;

        rows[0][0] = {16'd3, 16'd1, 12'h492};
        rows[0][1] = {16'd5, 16'd4, 12'h210};
        rows[0][2] = {16'd2, 16'd1, 12'hAAA};
        rows[0][3] = {16'd4, 16'd9, 12'h888};
        rows[1][0] = {16'd7, 16'd6, 12'h040};
        rows[1][1] = {16'd1, 16'd5, 12'hFFF};
        rows[1][2] = {16'd6, 16'd0, 12'h041};
        rows[1][3] = {16'd2, 16'd0, 12'h555};
        rows[2][0] = {16'd4, 16'd0, 12'h111};
        rows[2][1] = {16'd4, 16'd3, 12'h888};
        rows[2][2] = {16'd0, 16'd0, 12'h000};
        rows[2][3] = {16'd1, 16'd0, 12'hFFF};

        repeat (3) @(negedge refclk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_clken", 32'(clken), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_loss", 32'(lock_loss_cnt), 32'd0);

        // Lock present from reset release: RUN on the 11th edge, all channels at div=1.
        rst_n         = 1'b1;
        pll_locked_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge refclk);
            chk("lock_time", 32'(locked), (k >= 11) ? 32'd1 : 32'd0);
            chk("first_clken", 32'(clken), (k >= 11) ? 32'hF : 32'h0);
        end

        for (int r = 0; r < 3; r++) begin
            drops++;
            unlock();
            for (int c = 0; c < NCH; c++) begin
                cfg_write(3'(c), rows[r][c].div, rows[r][c].ph);
            end
            for (int k = 0; k < 12; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    e[c] = rows[r][c].mask[k];
                end
                sb_q.push_back(e);
            end
            relock(n);
            chk("relock_cycles", 32'(n), 32'd11);
            for (int k = 0; k < 12; k++) begin
                sb_check("row_clken");
                @(negedge refclk);
            end
        end

        // One-cycle lock glitch while running the last row configuration.
        pll_locked_in = 1'b0;
        @(negedge refclk);
        pll_locked_in = 1'b1;
        chk("glitch_e1", 32'(locked), 32'd1);
        @(negedge refclk);
        chk("glitch_e2", 32'(locked), 32'd1);
        @(negedge refclk);
        chk("glitch_e3_locked", 32'(locked), 32'd0);
        chk("glitch_e3_clken", 32'(clken), 32'd0);
        drops++;
        n = 3;
        while (!locked && n < 100) begin
            @(negedge refclk);
            n++;
        end
        chk("glitch_relock", 32'(n), 32'd12);
        chk("lock_loss", 32'(lock_loss_cnt), exp_loss(drops));

        // ch0 4 -> 6 written at cnt=1 lands on the wrap; chan 7 write is swallowed.
        for (int k = 0; k < 18; k++) begin
            e[0] = (k == 0) || (k >= 4 && ((k - 4) % 6) == 0);
            e[1] = (k % 4) == 3;
            e[2] = 1'b0;
            e[3] = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 18; k++) begin
            sb_check("wrap_clken");
            case (k)
                1: begin
                    chk("wrap_ready_k1", 32'(cfg_ready), 32'd1);
                    drive(3'd0, 16'd6, 16'd0);
                end
                2: begin
                    cfg_valid = 1'b0;
                    chk("wrap_ready_k2", 32'(cfg_ready), 32'd0);
                end
                3: chk("wrap_ready_k3", 32'(cfg_ready), 32'd0);
                4: chk("wrap_ready_k4", 32'(cfg_ready), 32'd1);
                5: drive(3'd7, 16'd2, 16'd1);
                6: begin
                    cfg_valid = 1'b0;
                    chk("bad_chan_ready", 32'(cfg_ready), 32'd1);
                end
                17: drive(3'd0, 16'd2, 16'd1);
                default: ;
            endcase
            @(negedge refclk);
        end
        cfg_valid = 1'b0;
        chk("pend_ready", 32'(cfg_ready), 32'd0);

        // Asynchronous reset with an update still pending.
        rst_n = 1'b0;
        #1;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_clken", 32'(clken), 32'd0);
        chk("midrst_ready", 32'(cfg_ready), 32'd1);
        chk("midrst_loss", 32'(lock_loss_cnt), 32'd0);
        drops = 0;
        @(negedge refclk);
        rst_n = 1'b1;
        relock(n);
        chk("post_rst_lock", 32'(n), 32'd11);
        chk("post_rst_clken0", 32'(clken), 32'hF);
        @(negedge refclk);
        chk("post_rst_clken1", 32'(clken), 32'hF);
        chk("post_rst_loss", 32'(lock_loss_cnt), exp_loss(drops));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
